kamikaze_imem_responder: RTL
============================

# kamikaze_imem_responder

Instruction-memory responder for the Kamikaze-uRV fetch port. Serves word requests from the fetch FIFO, which drives address/request and consumes ready/data, and bridges them onto a request/acknowledge instruction bus with arbitrary wait states. One-deep pipelined protocol: every ready cycle accepts the next address, and the word for that address is returned on the following ready cycle. Sits between the fetch FIFO and instruction SRAM/ROM or the bus arbiter.

## Interface
Parameters:
- RESET_DATA, 32'h0000_0013: ir_o value after reset/flush (NOP).

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  reset; asynchronous, active-low
- pc_i  in  32  fetch address from fetch FIFO; bits [1:0] ignored
- memory_request_i  in  1  fetch side wants service
- flush_i  in  1  branch; abandon in-flight fetch
- ir_o  out  32  returned instruction word (registered)
- memory_ready_o  out  1  ready/accept strobe to fetch FIFO
- mem_req_o  out  1  bus read request
- mem_addr_o  out  32  bus word address, {addr[31:2],2'b00}
- mem_rdata_i  in  32  bus read data
- mem_ack_i  in  1  bus acknowledge; data valid this cycle
- mem_err_i  in  1  bus error (only with KMKZ_IMEM_ERR_EN)
- fetch_err_o  out  1  word returned with bus error (only with KMKZ_IMEM_ERR_EN)

## Operation
- States: IDLE, ACCEPT, BUSY, VALID, DRAIN. memory_ready_o = (ACCEPT or VALID), Moore decode.
- IDLE: mem_req_o=0. memory_request_i=1 and flush_i=0 -> ACCEPT.
- ACCEPT: memory_ready_o=1, ir_o don't-care (fetch FIFO discards its first ready after start). Latch pc_i into addr reg at edge; -> BUSY.
- BUSY: mem_req_o=1; mem_addr_o, addr held stable until ack. mem_ack_i=1: ir_o<=mem_rdata_i, -> VALID.
- VALID: memory_ready_o=1, ir_o = word for addr reg. At edge: memory_request_i=1 -> latch pc_i, -> BUSY; else -> IDLE.
- Address re-presentation: fetch FIFO re-presents a previously accepted address when full; responder re-fetches whatever pc_i shows in a ready cycle, no comparison.
- flush_i (highest priority after reset):
  - IDLE/ACCEPT/VALID -> IDLE, no latch.
  - BUSY with mem_ack_i same cycle -> IDLE, data dropped.
  - BUSY without ack -> DRAIN.
  - DRAIN: mem_req_o=1, address held until mem_ack_i; data dropped, ir_o unchanged, -> IDLE. Further flush_i in DRAIN ignored.
- ir_o, fetch_err_o unchanged outside BUSY-ack capture; reset/flush sets ir_o=RESET_DATA.
- Bus never sees a second request before the ack of the first; at most one transaction outstanding.

## Timing
- Reset: state IDLE, addr=0, ir_o=RESET_DATA, memory_ready_o=0, mem_req_o=0, mem_addr_o=0, fetch_err_o=0.
- Zero-wait bus (ack in first BUSY cycle): steady-state BUSY/VALID alternate -> one word per 2 cycles.
- N wait states: one word per N+2 cycles.
- Start-up after reset/flush: ACCEPT appears 1 cycle after memory_request_i seen in IDLE; first data ready at ACCEPT + 2 cycles (zero-wait).
- Flush to next ACCEPT: 2 cycles without outstanding bus cycle; otherwise ack cycle + 2.
- Reset mid-transaction: outputs return to reset values immediately; bus slave must tolerate abandoned request.

## Configuration
- KMKZ_IMEM_ERR_EN defined: mem_err_i and fetch_err_o exist. mem_err_i treated as ack: ir_o<=32'h0000_0000 (illegal instruction), fetch_err_o<=1, -> VALID. fetch_err_o cleared on next capture, reset, flush. mem_err_i in DRAIN terminates drain like ack.
- Undefined: ports absent, no error path; bus must always ack.

## Test plan
- Reset release, memory_request_i=1, pc_i=0x100, zero-wait ROM -> ACCEPT cycle 1, mem_addr_o=0x100, first VALID ir_o=ROM[0x100], then 0x104, 0x108 every 2 cycles.
- 3 wait states per access -> mem_addr_o stable throughout, one VALID every 5 cycles, no duplicate ack consumption.
- pc_i=0x102 -> mem_addr_o=0x100.
- flush_i in BUSY, ack 2 cycles later, then pc_i=0x200 -> ack data never shows with memory_ready_o, next ACCEPT samples 0x200, ir_o=ROM[0x200].
- VALID with memory_request_i=0 -> IDLE, no bus request; re-raise -> ACCEPT precedes next data.
- KMKZ_IMEM_ERR_EN, mem_err_i on fetch of 0x300 -> ir_o=0x00000000, fetch_err_o=1 in VALID; next good fetch clears fetch_err_o.

Source files
------------

// File: rtl/kamikaze_imem_responder.sv
// ---------------------------------------------------------------------------
// kamikaze_imem_responder
//
// Purpose:
//   Instruction-memory responder for the Kamikaze-uRV fetch port. It takes
//   word requests from the fetch FIFO and issues them on a request/acknowledge
//   instruction bus that may insert any number of wait states.
//
//   The fetch side uses a one-deep pipelined protocol. Every cycle in which
//   memory_ready_o is high accepts the address on pc_i. The word for that
//   address is returned on ir_o in the next cycle in which memory_ready_o is
//   high.
//
// Handshake semantics (fetch side and bus side):
//   - Fetch side: memory_ready_o is a Moore strobe. In a ready cycle the
//     responder samples pc_i at the clock edge. It does so unconditionally
//     in ACCEPT, and in VALID only when memory_request_i is high. In VALID,
//     ir_o holds the word for the previously accepted address. In ACCEPT,
//     ir_o carries no new word.
//   - Bus side: mem_req_o rises with a stable mem_addr_o. Both stay unchanged
//     until the cycle in which mem_ack_i (or mem_err_i) is high. At most one
//     bus transaction is outstanding at any time. A reset is the only way to
//     abandon a request.
//
// Configuration:
//   KMKZ_IMEM_ERR_EN - when defined, adds mem_err_i / fetch_err_o. A bus
//   error completes the access like an ack, but it returns 32'h0000_0000
//   (illegal instruction) and raises fetch_err_o with that word. When the
//   macro is undefined, the error path and both ports are absent.
//
// Ports:
//   clk_i            core clock
//   rst_i            asynchronous active-low reset
//   pc_i             fetch address (bits [1:0] ignored)
//   memory_request_i fetch side wants service
//   flush_i          branch: abandon the in-flight fetch
//   ir_o             returned instruction word (registered)
//   memory_ready_o   ready/accept strobe to the fetch FIFO
//   mem_req_o        bus read request
//   mem_addr_o       bus word address {addr[31:2], 2'b00}
//   mem_rdata_i      bus read data
//   mem_ack_i        bus acknowledge, data valid this cycle
//   mem_err_i        bus error            (KMKZ_IMEM_ERR_EN only)
//   fetch_err_o      word carries bus err (KMKZ_IMEM_ERR_EN only)
// ---------------------------------------------------------------------------
module kamikaze_imem_responder #(
    parameter logic [31:0] RESET_DATA = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] pc_i,
    input  logic        memory_request_i,
    input  logic        flush_i,
    output logic [31:0] ir_o,
    output logic        memory_ready_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i
`ifdef KMKZ_IMEM_ERR_EN
    ,
    input  logic        mem_err_i,
    output logic        fetch_err_o
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCEPT = 3'd1,
        ST_BUSY   = 3'd2,
        ST_VALID  = 3'd3,
        ST_DRAIN  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] ir_q, ir_d;
    logic        ready_q;
    logic        req_q;
    logic        bus_done;
    logic        bus_err;
    logic        ferr_q, ferr_d;
    logic [31:0] pc_word;

    // The low address bits are explicitly forced to zero. The bus is word
    // addressed, and the fetch FIFO may present a misaligned pc.
    assign pc_word = {pc_i[31:2], pc_i[1:0] & 2'b00};

`ifdef KMKZ_IMEM_ERR_EN
    assign bus_err  = mem_err_i;
    assign bus_done = mem_ack_i | mem_err_i;
`else
    assign bus_err  = 1'b0;
    assign bus_done = mem_ack_i;
`endif

    // Next-state and datapath decode.
    // In every state except DRAIN, a flush returns the responder to IDLE with
    // ir_o reset to the NOP. DRAIN must not be cut short: the bus still owes
    // an acknowledge, and another request cannot be issued before that ack.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        ir_d    = ir_q;
        ferr_d  = ferr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (flush_i) begin
                    ir_d   = RESET_DATA;
                    ferr_d = 1'b0;
                end else if (memory_request_i) begin
                    state_d = ST_ACCEPT;
                end
            end
            ST_ACCEPT: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                    ir_d    = RESET_DATA;
                    ferr_d  = 1'b0;
                end else begin
                    // First ready after start-up: the address is taken
                    // whether or not memory_request_i is still high.
                    addr_d  = pc_word;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (flush_i) begin
                    ir_d    = RESET_DATA;
                    ferr_d  = 1'b0;
                    // When the ack arrives in the same cycle as the flush,
                    // the bus is already free. The returned data is dropped.
                    state_d = bus_done ? ST_IDLE : ST_DRAIN;
                end else if (bus_done) begin
                    ir_d    = bus_err ? 32'h0000_0000 : mem_rdata_i;
                    ferr_d  = bus_err;
                    state_d = ST_VALID;
                end
            end
            ST_VALID: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                    ir_d    = RESET_DATA;
                    ferr_d  = 1'b0;
                end else if (memory_request_i) begin
                    // No comparison with the previous address: a FIFO that
                    // re-presents an old pc simply gets that word re-fetched.
                    addr_d  = pc_word;
                    state_d = ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                // Ignore flush here. Wait for the outstanding ack, then drop
                // its data.
                if (bus_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // All state and outputs share one register block. The Moore outputs are
    // decoded from the next state, so each one is available as a flop output
    // in the same cycle in which its state is entered.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            addr_q  <= 32'h0000_0000;
            ir_q    <= RESET_DATA;
            ferr_q  <= 1'b0;
            ready_q <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            ir_q    <= ir_d;
            ferr_q  <= ferr_d;
            ready_q <= (state_d == ST_ACCEPT) || (state_d == ST_VALID);
            req_q   <= (state_d == ST_BUSY) || (state_d == ST_DRAIN);
        end
    end

    assign ir_o           = ir_q;
    assign memory_ready_o = ready_q;
    assign mem_req_o      = req_q;
    assign mem_addr_o     = addr_q;

`ifdef KMKZ_IMEM_ERR_EN
    assign fetch_err_o = ferr_q;
`else
    // Without the error path, ferr_q stays at zero. The register is kept so
    // that the datapath decode is the same in both builds.
    logic ferr_unused;
    assign ferr_unused = ferr_q;
`endif

endmodule
